ifc_bundle: RTL and testbench

- Shared signal bundle that carries a free-running cycle count and a 32-bit signed value to every consumer.
- Derives a packed struct from the value: val100 = value + OFFSET_A, val200 = value + OFFSET_B.
- Self-checks a struct driven back by an external producer against the derived value; mismatches set a sticky error.
- Raises a one-cycle done pulse at a programmed cycle; top-level testbenches and sub-units use it as the common handshake point.

---
 rtl/ifc_pkg.sv | 14 +
 rtl/ifc_struct_gen.sv | 21 ++
 rtl/ifc_bundle.sv | 58 +++++
 tb/tb_ifc_bundle.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifc_pkg.sv
// Shared types and default parameters for the ifc_bundle signal bundle.
package ifc_pkg;

  typedef struct packed {
    logic signed [31:0] val100;
    logic signed [31:0] val200;
  } struct_t;

  localparam int IFC_WIDTH      = 32;
  localparam int IFC_OFFSET_A   = 100;
  localparam int IFC_OFFSET_B   = 200;
  localparam int IFC_FINISH_CYC = 20;

endpackage

// File: rtl/ifc_struct_gen.sv
// Combinational value -> {val100, val200} adder pair; wraps modulo 2^WIDTH.
module ifc_struct_gen #(
  parameter int WIDTH    = 32,
  parameter int OFFSET_A = 100,
  parameter int OFFSET_B = 200
) (
  input  logic signed [WIDTH-1:0]   value,
  output logic        [2*WIDTH-1:0] st
);

  localparam logic signed [WIDTH-1:0] OFF_A = WIDTH'(OFFSET_A);
  localparam logic signed [WIDTH-1:0] OFF_B = WIDTH'(OFFSET_B);

  logic signed [WIDTH-1:0] val100, val200;

  // Truncating adds: two's-complement wrap, no saturation.
  assign val100 = value + OFF_A;
  assign val200 = value + OFF_B;
  assign st     = {val100, val200};

endmodule

// File: rtl/ifc_bundle.sv
// Cycle counter, value register, derived struct, sticky struct checker and
// a one-cycle done pulse at FINISH_CYC.
module ifc_bundle
  import ifc_pkg::*;
#(
  parameter int WIDTH      = IFC_WIDTH,
  parameter int OFFSET_A   = IFC_OFFSET_A,
  parameter int OFFSET_B   = IFC_OFFSET_B,
  parameter int FINISH_CYC = IFC_FINISH_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      value_wr,
  input  logic signed [WIDTH-1:0]   value_in,
  input  logic        [2*WIDTH-1:0] struct_in,
  input  logic                      struct_chk_en,
  output logic        [WIDTH-1:0]   cyc,
  output logic signed [WIDTH-1:0]   value,
  output logic        [2*WIDTH-1:0] the_struct,
  output logic                      chk_err,
  output logic                      done
);

  localparam logic [WIDTH-1:0] FIN = WIDTH'(FINISH_CYC);

  logic [WIDTH-1:0] cyc_nxt;
  logic             chk_miss;

  ifc_struct_gen #(
    .WIDTH    (WIDTH),
    .OFFSET_A (OFFSET_A),
    .OFFSET_B (OFFSET_B)
  ) u_gen (
    .value (value),
    .st    (the_struct)
  );

  assign cyc_nxt  = cyc + WIDTH'(1);
  // the_struct still reflects the pre-edge value, so a same-edge write is
  // not seen by the comparison.
  assign chk_miss = struct_chk_en && (struct_in != the_struct);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc     <= '0;
      value   <= '0;
      chk_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      cyc <= cyc_nxt;
      if (value_wr) value <= value_in;
      if (chk_miss) chk_err <= 1'b1;
      // Registered so done lines up with the cycle in which cyc == FINISH_CYC.
      done <= (cyc_nxt == FIN);
    end
  end

endmodule

// File: tb/tb_ifc_bundle.sv
// Directed self-checking bench for ifc_bundle (32-bit instance plus an
// 8-bit instance used to exercise counter wrap in a short run).
module tb_ifc_bundle;
  import ifc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               value_wr = 1'b0;
  logic signed [31:0] value_in = '0;
  struct_t            struct_in = '0;
  logic               struct_chk_en = 1'b0;
  logic [31:0]        cyc;
  logic signed [31:0] value;
  struct_t            the_struct;
  logic               chk_err, done;

  logic [7:0]  cyc8, value8;
  logic [15:0] struct8;
  logic        chk_err8, done8;

  int checks = 0;
  int errors = 0;

  ifc_bundle dut (
    .clk (clk), .rst (rst), .value_wr (value_wr), .value_in (value_in),
    .struct_in (struct_in), .struct_chk_en (struct_chk_en), .cyc (cyc),
    .value (value), .the_struct (the_struct), .chk_err (chk_err), .done (done)
  );

  ifc_bundle #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .value_wr (1'b0), .value_in (8'h00),
    .struct_in (16'h0000), .struct_chk_en (1'b0), .cyc (cyc8),
    .value (value8), .the_struct (struct8), .chk_err (chk_err8), .done (done8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (cyc !== 32'd0 || value !== 32'sd0 || chk_err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cyc=%0d value=%0d chk_err=%b done=%b, need 0 0 0 0",
               cyc, value, chk_err, done);
    end
    checks++;
    if (the_struct.val100 !== 32'sd100 || the_struct.val200 !== 32'sd200) begin
      errors++;
      $display("FAIL reset_struct: got {%0d,%0d} need {100,200}",
               the_struct.val100, the_struct.val200);
    end
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (cyc !== 32'(i)) begin
        errors++;
        $display("FAIL cyc_count: got %0d need %0d", cyc, i);
      end
    end
  endtask

  task automatic test_write();
    value_in = 32'sd5;
    value_wr = 1'b1;
    tick();
    value_wr = 1'b0;
    value_in = 32'sd77;
    checks++;
    if (value !== 32'sd5 || the_struct.val100 !== 32'sd105 || the_struct.val200 !== 32'sd205) begin
      errors++;
      $display("FAIL write5: value=%0d struct={%0d,%0d} need 5 {105,205}",
               value, the_struct.val100, the_struct.val200);
    end
    tick();
    checks++;
    if (value !== 32'sd5) begin
      errors++;
      $display("FAIL value_hold: got %0d need 5", value);
    end
  endtask

  task automatic test_match();
    value_in = 32'sd21;
    value_wr = 1'b1;
    tick();
    value_wr = 1'b0;
    struct_in.val100 = 32'sd121;
    struct_in.val200 = 32'sd221;
    struct_chk_en = 1'b1;
    tick();
    checks++;
    if (chk_err !== 1'b0) begin
      errors++;
      $display("FAIL match_check: chk_err=%b need 0", chk_err);
    end
    // Same-edge write and check: compare must use old value 21.
    value_in = 32'sd50;
    value_wr = 1'b1;
    tick();
    value_wr = 1'b0;
    struct_chk_en = 1'b0;
    checks++;
    if (chk_err !== 1'b0 || value !== 32'sd50) begin
      errors++;
      $display("FAIL write_and_check: chk_err=%b value=%0d need 0 50", chk_err, value);
    end
    // Restore value 21 for the mismatch test.
    value_in = 32'sd21;
    value_wr = 1'b1;
    tick();
    value_wr = 1'b0;
  endtask

  task automatic test_mismatch();
    struct_in.val100 = 32'sd121;
    struct_in.val200 = 32'sd222;
    struct_chk_en = 1'b1;
    tick();
    struct_chk_en = 1'b0;
    checks++;
    if (chk_err !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_set: chk_err=%b need 1", chk_err);
    end
    tick();
    checks++;
    if (chk_err !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_sticky: chk_err=%b need 1", chk_err);
    end
    struct_in.val200 = 32'sd221;
    struct_chk_en = 1'b1;
    tick();
    struct_chk_en = 1'b0;
    checks++;
    if (chk_err !== 1'b1) begin
      errors++;
      $display("FAIL sticky_after_match: chk_err=%b need 1", chk_err);
    end
  endtask

  task automatic test_wrap_values();
    value_in = -32'sd1;
    value_wr = 1'b1;
    tick();
    checks++;
    if (the_struct.val100 !== 32'sd99 || the_struct.val200 !== 32'sd199) begin
      errors++;
      $display("FAIL neg1_struct: got {%0d,%0d} need {99,199}",
               the_struct.val100, the_struct.val200);
    end
    value_in = 32'sh7FFF_FFFF;
    tick();
    value_wr = 1'b0;
    checks++;
    if (the_struct.val100 !== 32'sh8000_0063 || the_struct.val200 !== 32'sh8000_00C7) begin
      errors++;
      $display("FAIL max_struct: got {%h,%h} need {80000063,800000c7}",
               the_struct.val100, the_struct.val200);
    end
  endtask

  task automatic test_done();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (done === 1'b1) pulses++;
      checks++;
      if (done !== (i == 20) || cyc !== 32'(i)) begin
        errors++;
        $display("FAIL done_timing: cycle %0d cyc=%0d done=%b need cyc=%0d done=%b",
                 i, cyc, done, i, (i == 20));
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL done_pulse_count: got %0d need 1", pulses);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    value_in = 32'sd7;
    value_wr = 1'b1;
    struct_in = '0;
    struct_chk_en = 1'b1;
    tick();
    value_wr = 1'b0;
    struct_chk_en = 1'b0;
    for (int i = 2; i <= 10; i++) tick();
    checks++;
    if (cyc !== 32'd10 || value !== 32'sd7 || chk_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_async: cyc=%0d value=%0d chk_err=%b need 10 7 1", cyc, value, chk_err);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cyc !== 32'd0 || value !== 32'sd0 || chk_err !== 1'b0 || done !== 1'b0 ||
        the_struct.val100 !== 32'sd100 || the_struct.val200 !== 32'sd200) begin
      errors++;
      $display("FAIL async_reset: cyc=%0d value=%0d chk_err=%b done=%b, need all cleared",
               cyc, value, chk_err, done);
    end
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      checks++;
      if (done !== (i == 20) || cyc !== 32'(i)) begin
        errors++;
        $display("FAIL done_after_reset: cycle %0d cyc=%0d done=%b need done=%b",
                 i, cyc, done, (i == 20));
      end
    end
  endtask

  task automatic test_cyc_wrap();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (done8 === 1'b1) pulses++;
      if (i == 255) begin
        checks++;
        if (cyc8 !== 8'hFF) begin
          errors++;
          $display("FAIL cyc_top: got %h need ff", cyc8);
        end
      end
      if (i == 256) begin
        checks++;
        if (cyc8 !== 8'h00) begin
          errors++;
          $display("FAIL cyc_wrap: got %h need 00", cyc8);
        end
      end
      if (i == 276) begin
        checks++;
        if (done8 !== 1'b1 || cyc8 !== 8'd20) begin
          errors++;
          $display("FAIL done_after_wrap: done=%b cyc=%0d need 1 20", done8, cyc8);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL wrap_pulse_count: got %0d need 2", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_match();
    test_mismatch();
    test_wrap_values();
    test_done();
    test_async_reset();
    test_cyc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
